// File: rtl/game_pkg.sv
// Shared types and constants for the mental-arithmetic round sequencer.
// Holds the controller state enum (its encoding is driven out on the phase
// port), the accumulator modulus, and the score and display widths.
package game_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StShow   = 3'd2,
    StAnswer = 3'd3,
    StCheck  = 3'd4,
    StResult = 3'd5,
    StDone   = 3'd6
  } game_state_e;

  localparam int unsigned Mod    = 100;
  localparam int unsigned ScoreW = 3;
  localparam int unsigned DispW  = 8;

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter with a done flag.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-low reset
//   load     - load load_val this edge (takes priority over counting)
//   load_val - starting count; the flag is raised after load_val+1 cycles
//   done     - high while the count is zero
// The counter holds at zero, so done stays high until the next load.
module dwell_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer for the mental-arithmetic game.
// Fetches NUM_OPERANDS operands per round via a request/valid handshake,
// shows each for DWELL_CYCLES cycles, keeps a mod-100 running sum, captures
// and scores the player's answer, then shows the sum for DWELL_CYCLES cycles.
// Repeats for ROUNDS rounds, then shows the score.
// Ports:
//   clk, rst (sync, active-low), start (level)
//   rnd_req/rnd_valid/rnd_data - operand handshake with the random source
//   answer_valid/answer        - player answer strobe and value (0..99)
//   disp_value                 - value for the BCD converter
//   phase                      - current state encoding
//   score, correct, wrong, busy, game_over - status; all outputs registered
// Optional feature: define GAME_TIMEOUT_EN to bound the answer window to
// TIMEOUT_CYCLES cycles; an expired window scores as a wrong answer.
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int unsigned NUM_OPERANDS   = 5,
  parameter int unsigned OPERAND_W      = 5,
  parameter int unsigned DWELL_CYCLES   = 10,
  parameter int unsigned ROUNDS         = 7,
  parameter int unsigned TIMEOUT_CYCLES = 50
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 rnd_req,
  input  logic                 rnd_valid,
  input  logic [OPERAND_W-1:0] rnd_data,
  input  logic                 answer_valid,
  input  logic [7:0]           answer,
  output logic [DispW-1:0]     disp_value,
  output logic [2:0]           phase,
  output logic [ScoreW-1:0]    score,
  output logic                 correct,
  output logic                 wrong,
  output logic                 busy,
  output logic                 game_over
);

  localparam int unsigned TimerMax =
      (DWELL_CYCLES > TIMEOUT_CYCLES) ? DWELL_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned TimerW = (TimerMax > 1) ? $clog2(TimerMax) : 1;
  // Loading N-1 makes the timer report done on the Nth cycle of a state.
  localparam logic [TimerW-1:0] DwellLoad = TimerW'(DWELL_CYCLES - 1);
`ifdef GAME_TIMEOUT_EN
  localparam logic [TimerW-1:0] TimeoutLoad = TimerW'(TIMEOUT_CYCLES - 1);
`endif

  game_state_e state_q, state_d;
  logic [OPERAND_W-1:0] operand_q, operand_d;
  logic [6:0]  acc_q, acc_d;
  logic [7:0]  acc_sum;
  logic [3:0]  op_cnt_q, op_cnt_d;
  logic [2:0]  round_q, round_d;
  logic [ScoreW-1:0] score_q, score_d;
  logic [7:0]  ans_q, ans_d;
  logic        rnd_req_q, rnd_req_d;
  logic [DispW-1:0] disp_q, disp_d;
  logic        correct_q, correct_d;
  logic        wrong_q, wrong_d;
  logic        busy_q, busy_d;
  logic        game_over_q, game_over_d;
  logic        tmr_load;
  logic [TimerW-1:0] tmr_val;
  logic        tmr_done;

  dwell_timer #(
    .W (TimerW)
  ) u_dwell_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Operands are at most 31 and acc at most 99, so one subtract suffices.
  assign acc_sum = {1'b0, acc_q} + 8'(rnd_data);

  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    acc_d     = acc_q;
    op_cnt_d  = op_cnt_q;
    round_d   = round_q;
    score_d   = score_q;
    ans_d     = ans_q;
    correct_d = 1'b0;
    wrong_d   = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = DwellLoad;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          score_d  = '0;
          round_d  = '0;
          op_cnt_d = '0;
          acc_d    = '0;
          state_d  = StFetch;
        end
      end
      StFetch: begin
        if (rnd_valid) begin
          operand_d = rnd_data;
          acc_d     = (acc_sum >= 8'(Mod)) ? 7'(acc_sum - 8'(Mod)) : acc_sum[6:0];
          op_cnt_d  = op_cnt_q + 4'd1;
          tmr_load  = 1'b1;
          state_d   = StShow;
        end
      end
      StShow: begin
        if (tmr_done) begin
          if (op_cnt_q < 4'(NUM_OPERANDS)) begin
            state_d = StFetch;
          end else begin
            state_d = StAnswer;
`ifdef GAME_TIMEOUT_EN
            tmr_load = 1'b1;
            tmr_val  = TimeoutLoad;
`endif
          end
        end
      end
      StAnswer: begin
        if (answer_valid) begin
          ans_d   = answer;
          state_d = StCheck;
`ifdef GAME_TIMEOUT_EN
        end else if (tmr_done) begin
          // acc never reaches 0xFF, so this forces a mismatch in CHECK.
          ans_d   = 8'hFF;
          state_d = StCheck;
`endif
        end
      end
      StCheck: begin
        if (ans_q == {1'b0, acc_q}) begin
          correct_d = 1'b1;
          if (score_q != '1) begin
            score_d = score_q + ScoreW'(1);
          end
        end else begin
          wrong_d = 1'b1;
        end
        tmr_load = 1'b1;
        state_d  = StResult;
      end
      StResult: begin
        if (tmr_done) begin
          round_d = round_q + 3'd1;
          if (round_q + 3'd1 == 3'(ROUNDS)) begin
            state_d = StDone;
          end else begin
            acc_d    = '0;
            op_cnt_d = '0;
            state_d  = StFetch;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered, so they are decoded from the next-state values.
    rnd_req_d   = (state_d == StFetch);
    busy_d      = !(state_d inside {StIdle, StDone});
    game_over_d = (state_d == StDone);
    case (state_d)
      StShow:   disp_d = DispW'(operand_d);
      StResult: disp_d = DispW'(acc_d);
      StDone:   disp_d = DispW'(score_d);
      default:  disp_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      operand_q   <= '0;
      acc_q       <= '0;
      op_cnt_q    <= '0;
      round_q     <= '0;
      score_q     <= '0;
      ans_q       <= '0;
      rnd_req_q   <= 1'b0;
      disp_q      <= '0;
      correct_q   <= 1'b0;
      wrong_q     <= 1'b0;
      busy_q      <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      operand_q   <= operand_d;
      acc_q       <= acc_d;
      op_cnt_q    <= op_cnt_d;
      round_q     <= round_d;
      score_q     <= score_d;
      ans_q       <= ans_d;
      rnd_req_q   <= rnd_req_d;
      disp_q      <= disp_d;
      correct_q   <= correct_d;
      wrong_q     <= wrong_d;
      busy_q      <= busy_d;
      game_over_q <= game_over_d;
    end
  end

  assign rnd_req    = rnd_req_q;
  assign disp_value = disp_q;
  assign phase      = state_q;
  assign score      = score_q;
  assign correct    = correct_q;
  assign wrong      = wrong_q;
  assign busy       = busy_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed self-checking bench for game_round_ctrl at default parameters.
module tb_game_round_ctrl;
  import game_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic       rnd_req;
  logic       rnd_valid;
  logic [4:0] rnd_data;
  logic       answer_valid;
  logic [7:0] answer;
  logic [7:0] disp_value;
  logic [2:0] phase;
  logic [2:0] score;
  logic       correct;
  logic       wrong;
  logic       busy;
  logic       game_over;

  int n_checks = 0;
  int n_pass   = 0;

  game_round_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .rnd_req      (rnd_req),
    .rnd_valid    (rnd_valid),
    .rnd_data     (rnd_data),
    .answer_valid (answer_valid),
    .answer       (answer),
    .disp_value   (disp_value),
    .phase        (phase),
    .score        (score),
    .correct      (correct),
    .wrong        (wrong),
    .busy         (busy),
    .game_over    (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rnd_req"}, int'(rnd_req), 0);
    check({tag, "_disp"}, int'(disp_value), 0);
    check({tag, "_phase"}, int'(phase), int'(StIdle));
    check({tag, "_score"}, int'(score), 0);
    check({tag, "_correct"}, int'(correct), 0);
    check({tag, "_wrong"}, int'(wrong), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_game_over"}, int'(game_over), 0);
  endtask

  // Entered in a FETCH cycle; leaves at the first cycle after SHOW.
  task automatic play_operand(input logic [4:0] v, input int dly, input bit hold,
                              input bit inject);
    int  n;
    bit  held_ok;
    check("fetch_phase", int'(phase), int'(StFetch));
    check("fetch_req", int'(rnd_req), 1);
    if (dly > 0) begin
      held_ok   = 1'b1;
      rnd_valid = 1'b0;
      repeat (dly) begin
        step();
        if (rnd_req !== 1'b1 || phase !== 3'(StFetch)) held_ok = 1'b0;
      end
      check("req_held_while_waiting", int'(held_ok), 1);
    end
    rnd_data  = v;
    rnd_valid = 1'b1;
    step();
    if (!hold) rnd_valid = 1'b0;
    check("show_phase", int'(phase), int'(StShow));
    check("show_disp", int'(disp_value), int'(v));
    check("req_low_after_capture", int'(rnd_req), 0);
    n = 0;
    do begin
      n++;
      if (inject && n == 3) begin
        answer_valid = 1'b1;
        answer       = 8'd0;
        start        = 1'b1;
        step();
        answer_valid = 1'b0;
        start        = 1'b0;
      end else begin
        step();
      end
    end while (phase == 3'(StShow) && n < 100);
    check("show_cycles", n, 10);
  endtask

  task automatic play_ops(input logic [4:0] o0, input logic [4:0] o1, input logic [4:0] o2,
                          input logic [4:0] o3, input logic [4:0] o4, input int dly,
                          input bit hold, input bit inject);
    play_operand(o0, dly, hold, inject);
    play_operand(o1, dly, hold, 1'b0);
    play_operand(o2, dly, hold, 1'b0);
    play_operand(o3, dly, hold, 1'b0);
    play_operand(o4, dly, hold, 1'b0);
    rnd_valid = 1'b0;
    check("answer_phase", int'(phase), int'(StAnswer));
    check("answer_disp", int'(disp_value), 0);
  endtask

  // Entered in an ANSWER cycle; leaves at the first cycle after RESULT.
  task automatic give_answer(input logic [7:0] ans, input int exp_acc, input bit exp_ok,
                             input int exp_score, input bit last);
    int n;
    int echo;
    step();
    step();
    answer_valid = 1'b1;
    answer       = ans;
    step();
    answer_valid = 1'b0;
    check("check_phase", int'(phase), int'(StCheck));
    check("no_early_pulse", int'(correct | wrong), 0);
    step();
    check("result_phase", int'(phase), int'(StResult));
    check("correct_pulse", int'(correct), int'(exp_ok));
    check("wrong_pulse", int'(wrong), int'(!exp_ok));
    check("result_score", int'(score), exp_score);
    check("result_disp", int'(disp_value), exp_acc);
    n    = 0;
    echo = 0;
    do begin
      n++;
      step();
      if (n == 1) echo = int'(correct | wrong);
    end while (phase == 3'(StResult) && n < 100);
    check("pulse_one_cycle", echo, 0);
    check("result_cycles", n, 10);
    check("after_result_phase", int'(phase), last ? int'(StDone) : int'(StFetch));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  stay_ok;
    rst          = 1'b0;
    start        = 1'b0;
    rnd_valid    = 1'b0;
    rnd_data     = '0;
    answer_valid = 1'b0;
    answer       = '0;
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b1;
    step();
    check("idle_hold", int'(phase), int'(StIdle));

    // Game 1
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_req", int'(rnd_req), 1);
    check("start_busy", int'(busy), 1);
    // 3+7+12+31+20 = 73
    play_ops(5'd3, 5'd7, 5'd12, 5'd31, 5'd20, 0, 1'b1, 1'b0);
    give_answer(8'd73, 73, 1'b1, 1, 1'b0);
    // 31*5 = 155 -> 55
    play_ops(5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 0, 1'b1, 1'b0);
    give_answer(8'd55, 55, 1'b1, 2, 1'b0);
    // Delayed handshake, ignored answer/start during SHOW; sum exactly 100 -> 0
    play_ops(5'd10, 5'd20, 5'd30, 5'd31, 5'd9, 4, 1'b0, 1'b1);
    give_answer(8'd0, 0, 1'b1, 3, 1'b0);
    // Raw unreduced sum is not accepted
    play_ops(5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 0, 1'b0, 1'b0);
    give_answer(8'd155, 55, 1'b0, 3, 1'b0);
    play_ops(5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 0, 1'b0, 1'b0);
    give_answer(8'd15, 15, 1'b1, 4, 1'b0);
    play_ops(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 1'b0, 1'b0);
    give_answer(8'd1, 0, 1'b0, 4, 1'b0);
    play_ops(5'd25, 5'd25, 5'd25, 5'd24, 5'd0, 0, 1'b0, 1'b0);
    give_answer(8'd99, 99, 1'b1, 5, 1'b1);
    check("done_game_over", int'(game_over), 1);
    check("done_busy", int'(busy), 0);
    check("done_disp", int'(disp_value), 5);
    check("done_score", int'(score), 5);
    check("done_req", int'(rnd_req), 0);

    // Game 2: restart from DONE, reset during ANSWER of round 3
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_phase", int'(phase), int'(StFetch));
    check("restart_score", int'(score), 0);
    check("restart_game_over", int'(game_over), 0);
    play_ops(5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 0, 1'b0, 1'b0);
    give_answer(8'd15, 15, 1'b1, 1, 1'b0);
    play_ops(5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 0, 1'b0, 1'b0);
    give_answer(8'd55, 55, 1'b1, 2, 1'b0);
    play_ops(5'd9, 5'd9, 5'd9, 5'd9, 5'd9, 0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    check_reset_outputs("midgame_reset");
    step();
    check("idle_after_reset", int'(phase), int'(StIdle));
    start = 1'b1;
    step();
    start = 1'b0;
    check("reset_restart_req", int'(rnd_req), 1);
    check("reset_restart_score", int'(score), 0);
    play_ops(5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 0, 1'b0, 1'b0);

`ifdef GAME_TIMEOUT_EN
    // Just past the ANSWER entry edge; wrong should appear after edge 51.
    n = 0;
    while (wrong !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check("timeout_edges", n, 51);
    check("timeout_score", int'(score), 0);
    check("timeout_no_correct", int'(correct), 0);
`else
    stay_ok = 1'b1;
    n = 0;
    repeat (1000) begin
      step();
      n++;
      if (phase !== 3'(StAnswer) || wrong !== 1'b0) stay_ok = 1'b0;
    end
    check("answer_waits", int'(stay_ok), 1);
    check("answer_wait_cycles", n, 1000);
    give_answer(8'd15, 15, 1'b1, 1, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
